spi_slave_mode: RTL and testbench
=================================

SPI_SLAVE_MODE -- requirements
Module: spi_slave_mode

Interface
REQ-001 Parameter WIDTH, default 8: word length in bits, any value 4..32.
REQ-002 Parameter CPOL, default 0: SCK idle level.
REQ-003 Parameter CPHA, default 1: 0 = sample leading edge; 1 = sample trailing edge.
REQ-004 Parameter LSB_FIRST, default 0: 1 = bit 0 shifted first on both IO0 and IO1.
REQ-005 Parameter SYNC_STAGES, default 2: synchroniser depth, 2..4.
REQ-006 Parameter IDLE_WORD, default all-zeros: word driven on MISO on underrun.
REQ-007 Port clk, input, 1: single system clock.
REQ-008 Port rst, input, 1: reset; synchronous to clk, active-high.
REQ-009 Ports SS_I, SCK_I, IO0_I, inputs, 1 each: chip select (active-low), serial clock, MOSI.
REQ-010 Ports IO1_O, IO1_T, outputs, 1 each: MISO data; tristate, 1 = released.
REQ-011 Port m_data, output, WIDTH: last complete received word.
REQ-012 Port m_valid, output, 1: one-cycle pulse per received word; no backpressure.
REQ-013 Ports s_data (input, WIDTH), s_valid (input, 1), s_ready (output, 1): tx word handshake; transfer when s_valid && s_ready.
REQ-014 Ports tx_underrun, frame_err, outputs, 1 each: one-cycle status pulses.
REQ-015 Port busy, output, 1: FSM in ACTIVE.

Function
REQ-016 SCK_I, SS_I, IO0_I SHALL pass through SYNC_STAGES flops; normalised clock = synced SCK XOR CPOL.
REQ-017 Leading edge = normalised 0->1; trailing edge = 1->0; both qualified by synced SS low and state ACTIVE.
REQ-018 Sample edge = leading if CPHA=0, else trailing; shift edge = the other.
REQ-019 FSM states: WAIT_IDLE, IDLE, ACTIVE. WAIT_IDLE->IDLE when synced SS high; IDLE->ACTIVE on synced SS fall; ACTIVE->IDLE on synced SS rise.
REQ-020 Bit counter (clog2(WIDTH) bits) SHALL clear on ACTIVE entry, increment per sample edge, wrap to 0 after WIDTH-1; frames of any number of words are supported.
REQ-021 m_valid SHALL pulse the clk cycle after the sample edge completing a word; m_data updates in that same cycle and holds until the next pulse.
REQ-022 Load point: CPHA=0 -- ACTIVE entry and each shift edge following a word's last sample; CPHA=1 -- each shift edge with tx bit counter 0.
REQ-023 s_ready SHALL be high for exactly the load-point cycle; if s_valid, s_data is loaded, else IDLE_WORD is loaded and tx_underrun pulses the same cycle.
REQ-024 IO1_O SHALL update from a register on load points and shift edges only, first bit per LSB_FIRST.
REQ-025 IO1_T SHALL equal SS_I unsynchronised (released immediately on deselect).
REQ-026 SS rise with rx bit counter non-zero SHALL discard the partial word (no m_valid) and pulse frame_err.
REQ-027 SCK edges while SS high SHALL be ignored; SCK high and low phases SHALL each last at least SYNC_STAGES+2 clk periods.

Reset
REQ-028 On rst: state WAIT_IDLE; m_data, m_valid, s_ready, tx_underrun, frame_err, busy, IO1_O, all counters and shift registers 0.
REQ-029 Reset asserted mid-frame SHALL abort it; no word is received or transmitted until SS has been seen high, then low.

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state encoding and CPOL/CPHA mode constants.
REQ-031 Sub-module spi_slave_sync SHALL implement the parametrised multi-bit synchroniser; all other logic stays in spi_slave_mode.

Verification
REQ-032 WIDTH=8, CPOL=0, CPHA=1, master sends 0xA5 while s_data=0x3C presented -> m_data=0xA5 with one m_valid; master reads 0x3C; s_ready pulsed once.
REQ-033 All four CPOL/CPHA combos, WIDTH=16, LSB_FIRST=1, send 0x1234 -> m_data=0x1234, MISO bits LSB first, each mode.
REQ-034 Three back-to-back words in one frame, s_valid low for word 2 -> words 1/3 from s_data, word 2 = IDLE_WORD, tx_underrun one pulse.
REQ-035 SS raised after 5 of 8 bits -> no m_valid, frame_err one pulse, next frame of 0x81 received correctly.
REQ-036 rst asserted at bit 3 and released with SS still low -> no m_valid and busy=0 until SS cycles high then low; next word 0x5A received correctly.
REQ-037 SCK toggling with SS high -> no m_valid, s_ready, or IO1_O change; IO1_T=1 throughout.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_pkg : FSM state encoding and SPI clock-mode constants             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package spi_pkg;

    localparam logic [1:0] c_st_wait_idle = 2'd0;
    localparam logic [1:0] c_st_idle      = 2'd1;
    localparam logic [1:0] c_st_active    = 2'd2;

    localparam int c_cpol_idle_low  = 0;
    localparam int c_cpol_idle_high = 1;
    localparam int c_cpha_leading   = 0;
    localparam int c_cpha_trailing  = 1;

endpackage
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_slave_sync : parametrised multi-bit flop-chain synchroniser       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_mode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_slave_mode : oversampled SPI slave, configurable CPOL/CPHA/order  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module spi_slave_mode
    import spi_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CPOL        = 0,
    parameter int               CPHA        = 1,
    parameter int               LSB_FIRST   = 0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS_I,
    input  logic             SCK_I,
    input  logic             IO0_I,
    output logic             IO1_O,
    output logic             IO1_T,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             tx_underrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int              c_cw          = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last        = c_cw'(WIDTH - 1);
    localparam logic            c_cpol        = (CPOL != c_cpol_idle_low);
    localparam logic            c_sample_lead = (CPHA == c_cpha_leading);

    logic [2:0]       w_sync_out;
    logic             w_ss_s, w_sck_s, w_mosi_s, w_norm;
    logic             w_lead, w_trail, w_sample, w_shift, w_load;
    logic             w_in_idle, w_in_active, w_enter;
    logic [1:0]       r_state, w_next_state;
    logic             r_norm_prev, r_word_done, r_io1, r_m_valid;
    logic [c_cw-1:0]  r_rx_cnt, r_tx_cnt;
    logic [WIDTH-2:0] r_rx_sr, w_rx_keep;
    logic [WIDTH-1:0] w_rx_next, r_tx_sr, w_tx_rot, w_tx_word, r_m_data;
    logic             w_load_bit, w_shift_bit;

    spi_slave_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({SS_I, SCK_I, IO0_I}),
        .q   (w_sync_out)
    );

    assign w_ss_s   = w_sync_out[2];
    assign w_sck_s  = w_sync_out[1];
    assign w_mosi_s = w_sync_out[0];
    assign w_norm   = w_sck_s ^ c_cpol;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_wait_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_wait_idle: if (w_ss_s)  w_next_state = c_st_idle;
            c_st_idle:      if (!w_ss_s) w_next_state = c_st_active;
            c_st_active:    if (w_ss_s)  w_next_state = c_st_idle;
            default:                     w_next_state = c_st_wait_idle;
        endcase
    end

    always_comb begin
        w_in_idle   = (r_state == c_st_idle);
        w_in_active = (r_state == c_st_active);
        busy        = w_in_active;
    end

    assign w_enter  = w_in_idle & ~w_ss_s;
    assign w_lead   = w_in_active & ~w_ss_s &  w_norm & ~r_norm_prev;
    assign w_trail  = w_in_active & ~w_ss_s & ~w_norm &  r_norm_prev;
    assign w_sample = c_sample_lead ? w_lead  : w_trail;
    assign w_shift  = c_sample_lead ? w_trail : w_lead;

    // Mode 0/2 must present bit 0 before the first edge, so it preloads on select.
    assign w_load = c_sample_lead ? (w_enter | (w_shift & r_word_done))
                                  : (w_shift & (r_tx_cnt == '0));

    assign w_tx_word   = s_valid ? s_data : IDLE_WORD;
    assign s_ready     = w_load;
    assign tx_underrun = w_load & ~s_valid;
    assign frame_err   = w_in_active & w_ss_s & (r_rx_cnt != '0);

    // rx keeps only the WIDTH-1 most recent bits; the word is completed by the live bit.
    if (LSB_FIRST != 0) begin : g_lsb_first
        assign w_rx_next   = {w_mosi_s, r_rx_sr};
        assign w_rx_keep   = w_rx_next[WIDTH-1:1];
        assign w_tx_rot    = {r_tx_sr[0], r_tx_sr[WIDTH-1:1]};
        assign w_load_bit  = w_tx_word[0];
        assign w_shift_bit = w_tx_rot[0];
    end else begin : g_msb_first
        assign w_rx_next   = {r_rx_sr, w_mosi_s};
        assign w_rx_keep   = w_rx_next[WIDTH-2:0];
        assign w_tx_rot    = {r_tx_sr[WIDTH-2:0], r_tx_sr[WIDTH-1]};
        assign w_load_bit  = w_tx_word[WIDTH-1];
        assign w_shift_bit = w_tx_rot[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_norm_prev <= 1'b0;
            r_rx_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_word_done <= 1'b0;
            r_io1       <= 1'b0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
        end else begin
            r_norm_prev <= w_norm;
            r_m_valid   <= 1'b0;
            if (!w_in_active) begin
                r_rx_cnt    <= '0;
                r_tx_cnt    <= '0;
                r_word_done <= 1'b0;
            end else begin
                if (w_sample) begin
                    r_rx_sr  <= w_rx_keep;
                    r_rx_cnt <= (r_rx_cnt == c_last) ? '0 : r_rx_cnt + 1'b1;
                    if (r_rx_cnt == c_last) begin
                        r_m_valid   <= 1'b1;
                        r_m_data    <= w_rx_next;
                        r_word_done <= 1'b1;
                    end
                end
                if (w_shift) begin
                    r_word_done <= 1'b0;
                    r_tx_cnt    <= (r_tx_cnt == c_last) ? '0 : r_tx_cnt + 1'b1;
                end
            end
            if (w_load) begin
                r_tx_sr <= w_tx_word;
                r_io1   <= w_load_bit;
            end else if (w_shift) begin
                r_tx_sr <= w_tx_rot;
                r_io1   <= w_shift_bit;
            end
        end
    end

    assign IO1_O   = r_io1;
    assign IO1_T   = SS_I;
    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_mode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_spi_slave_mode : directed + randomised bench with SPI master model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_spi_slave_mode;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0]  ss_all, sck_all, miso_all, t_all;
    logic        mosi;
    logic [7:0]  m_data0, s_data0;
    logic        m_valid0, s_valid0, s_ready0, und0, fe0, busy0;
    logic [15:0] md_m [4];
    logic [3:0]  mv_m, sr_m, und_m, fe_m, busy_m;
    logic [15:0] s_data_m;
    logic        s_valid_m;

    spi_slave_mode u_dut (
        .clk         (clk),
        .rst         (rst),
        .SS_I        (ss_all[0]),
        .SCK_I       (sck_all[0]),
        .IO0_I       (mosi),
        .IO1_O       (miso_all[0]),
        .IO1_T       (t_all[0]),
        .m_data      (m_data0),
        .m_valid     (m_valid0),
        .s_data      (s_data0),
        .s_valid     (s_valid0),
        .s_ready     (s_ready0),
        .tx_underrun (und0),
        .frame_err   (fe0),
        .busy        (busy0)
    );

    for (genvar k = 0; k < 4; k++) begin : g_mode
        spi_slave_mode #(
            .WIDTH     (16),
            .CPOL      (k / 2),
            .CPHA      (k % 2),
            .LSB_FIRST (1)
        ) u_m (
            .clk         (clk),
            .rst         (rst),
            .SS_I        (ss_all[k+1]),
            .SCK_I       (sck_all[k+1]),
            .IO0_I       (mosi),
            .IO1_O       (miso_all[k+1]),
            .IO1_T       (t_all[k+1]),
            .m_data      (md_m[k]),
            .m_valid     (mv_m[k]),
            .s_data      (s_data_m),
            .s_valid     (s_valid_m),
            .s_ready     (sr_m[k]),
            .tx_underrun (und_m[k]),
            .frame_err   (fe_m[k]),
            .busy        (busy_m[k])
        );
    end

    int checks = 0;
    int errors = 0;
    int mv_cnt = 0, sr_cnt = 0, und_cnt = 0, fe_cnt = 0;
    int mv_m_cnt [4] = '{default: 0};
    int sr_m_cnt [4] = '{default: 0};
    int und_m_cnt[4] = '{default: 0};
    int fe_m_cnt [4] = '{default: 0};
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (m_valid0) begin
            mv_cnt++;
            rxq.push_back(m_data0);
        end
        if (s_ready0) sr_cnt++;
        if (und0)     und_cnt++;
        if (fe0)      fe_cnt++;
        for (int k = 0; k < 4; k++) begin
            if (mv_m[k])  mv_m_cnt[k]++;
            if (sr_m[k])  sr_m_cnt[k]++;
            if (und_m[k]) und_m_cnt[k]++;
            if (fe_m[k])  fe_m_cnt[k]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bit of a master transfer; returns the MISO value the master samples.
    task automatic send_bit(input int ch, input logic cpol, input logic cpha,
                            input logic b, output logic m);
        if (!cpha) begin
            mosi = b;
            repeat (HALF) @(negedge clk);
            m = miso_all[ch];
            sck_all[ch] = ~cpol;
            repeat (HALF) @(negedge clk);
            sck_all[ch] = cpol;
        end else begin
            sck_all[ch] = ~cpol;
            mosi = b;
            repeat (HALF) @(negedge clk);
            m = miso_all[ch];
            sck_all[ch] = cpol;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic frame0(input int nbits, input logic [23:0] words, input logic [2:0] valids,
                          input logic [23:0] sdat, output logic [23:0] mw);
        int k, j;
        logic b;
        mw = '0;
        ss_all[0] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            k = i / 8;
            j = i % 8;
            if (j == 0) begin
                s_data0  = sdat[k*8 +: 8];
                s_valid0 = valids[k];
            end
            send_bit(0, 1'b0, 1'b1, words[k*8 + 7 - j], b);
            mw[k*8 + 7 - j] = b;
        end
        repeat (HALF) @(negedge clk);
        ss_all[0] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic frame_m(input int k, input logic [15:0] w, output logic [15:0] mi);
        logic b;
        logic cp, ch;
        cp = (k >= 2);
        ch = (k % 2) == 1;
        mi = '0;
        ss_all[k+1] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            send_bit(k + 1, cp, ch, w[i], b);
            mi[i] = b;
        end
        repeat (HALF) @(negedge clk);
        ss_all[k+1] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [23:0] words, sdat, mw;
        logic [2:0]  valids;
        logic [15:0] mi, w16;
        logic        b, io_prev;
        int          nw, s_mv, s_sr, s_und, s_fe, exp_und;

        rst = 1'b1;
        ss_all = '1;
        sck_all = 5'b11000;
        mosi = 1'b0;
        s_data0 = '0;
        s_valid0 = 1'b0;
        s_data_m = '0;
        s_valid_m = 1'b1;
        repeat (4) @(negedge clk);

        check("rst_m_data",  m_data0,     8'h00);
        check("rst_m_valid", m_valid0,    1'b0);
        check("rst_s_ready", s_ready0,    1'b0);
        check("rst_underrun", und0,       1'b0);
        check("rst_frame_err", fe0,       1'b0);
        check("rst_busy",    busy0,       1'b0);
        check("rst_io1_o",   miso_all[0], 1'b0);
        check("rst_io1_t",   t_all[0],    1'b1);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Single word, mode 1.
        s_mv = mv_cnt; s_sr = sr_cnt; s_und = und_cnt; s_fe = fe_cnt;
        frame0(8, 24'h0000A5, 3'b001, 24'h00003C, mw);
        check("w1_mv_count", mv_cnt - s_mv, 1);
        check("w1_rx_word",  rxq.pop_front(), 8'hA5);
        check("w1_m_data",   m_data0, 8'hA5);
        check("w1_miso",     mw[7:0], 8'h3C);
        check("w1_s_ready",  sr_cnt - s_sr, 1);
        check("w1_underrun", und_cnt - s_und, 0);
        check("w1_frame_err", fe_cnt - s_fe, 0);

        // Three words, s_valid low for the second.
        words = 24'($urandom);
        sdat  = 24'($urandom);
        s_mv = mv_cnt; s_sr = sr_cnt; s_und = und_cnt;
        frame0(24, words, 3'b101, sdat, mw);
        check("w3_mv_count", mv_cnt - s_mv, 3);
        for (int k = 0; k < 3; k++) begin
            if (rxq.size() > 0) check("w3_rx_word", rxq.pop_front(), words[k*8 +: 8]);
        end
        check("w3_miso_w1",  mw[7:0],   sdat[7:0]);
        check("w3_miso_w2",  mw[15:8],  8'h00);
        check("w3_miso_w3",  mw[23:16], sdat[23:16]);
        check("w3_underrun", und_cnt - s_und, 1);
        check("w3_s_ready",  sr_cnt - s_sr, 3);

        // Truncated frame then a clean one.
        s_mv = mv_cnt; s_fe = fe_cnt;
        frame0(5, 24'($urandom), 3'b001, 24'h0000FF, mw);
        check("trunc_mv",  mv_cnt - s_mv, 0);
        check("trunc_ferr", fe_cnt - s_fe, 1);
        frame0(8, 24'h000081, 3'b001, 24'h000011, mw);
        check("after_trunc_rx", (rxq.size() == 1) ? rxq.pop_front() : 8'hxx, 8'h81);
        check("after_trunc_ferr", fe_cnt - s_fe, 1);

        // Reset in the middle of a frame with SS held low.
        s_mv = mv_cnt;
        w16 = 16'h00C3;
        ss_all[0] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b0, 1'b1, w16[7-i], b);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_m_data", m_data0, 8'h00);
        for (int i = 3; i < 8; i++) begin
            send_bit(0, 1'b0, 1'b1, w16[7-i], b);
            check("midrst_busy", busy0, 1'b0);
        end
        repeat (HALF) @(negedge clk);
        ss_all[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_mv", mv_cnt - s_mv, 0);
        frame0(8, 24'h00005A, 3'b001, 24'h000000, mw);
        check("midrst_next_rx", (rxq.size() == 1) ? rxq.pop_front() : 8'hxx, 8'h5A);

        // SCK activity while deselected.
        s_mv = mv_cnt; s_sr = sr_cnt;
        io_prev = miso_all[0];
        for (int i = 0; i < 10; i++) begin
            sck_all[0] = ~sck_all[0];
            mosi = 1'($urandom);
            repeat (HALF) @(negedge clk);
            check("desel_io1_t", t_all[0], 1'b1);
        end
        check("desel_io1_o", miso_all[0], io_prev);
        check("desel_mv", mv_cnt - s_mv, 0);
        check("desel_s_ready", sr_cnt - s_sr, 0);

        // All four clock modes, 16-bit LSB-first.
        s_data_m = 16'($urandom);
        w16 = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            s_mv = mv_m_cnt[k]; s_sr = sr_m_cnt[k];
            frame_m(k, w16, mi);
            check("mode_m_data", md_m[k], 16'h1234);
            check("mode_mv", mv_m_cnt[k] - s_mv, 1);
            check("mode_miso", mi, s_data_m);
            // Modes with CPHA=0 preload on select and again after the last word.
            check("mode_s_ready", sr_m_cnt[k] - s_sr, ((k % 2) == 0) ? 2 : 1);
            check("mode_ferr", fe_m_cnt[k], 0);
            check("mode_underrun", und_m_cnt[k], 0);
        end

        // Randomised frames against the word-level model.
        for (int it = 0; it < 6; it++) begin
            nw     = $urandom_range(1, 3);
            words  = 24'($urandom);
            sdat   = 24'($urandom);
            valids = 3'($urandom);
            exp_und = 0;
            for (int k = 0; k < nw; k++) if (!valids[k]) exp_und++;
            s_mv = mv_cnt; s_sr = sr_cnt; s_und = und_cnt; s_fe = fe_cnt;
            frame0(nw * 8, words, valids, sdat, mw);
            check("rnd_mv", mv_cnt - s_mv, nw);
            for (int k = 0; k < nw; k++) begin
                if (rxq.size() > 0) check("rnd_rx", rxq.pop_front(), words[k*8 +: 8]);
                check("rnd_miso", mw[k*8 +: 8], valids[k] ? sdat[k*8 +: 8] : 8'h00);
            end
            check("rnd_underrun", und_cnt - s_und, exp_und);
            check("rnd_s_ready", sr_cnt - s_sr, nw);
            check("rnd_ferr", fe_cnt - s_fe, 0);
        end
        check("rxq_empty", rxq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
